// File: rtl/ocx_tlx_ctl_router_if.sv
// Bundle of parser, VC FIFO, data-arbiter and credit-return signals for ocx_tlx_ctl_router.
// The router takes the slave modport; its upstream/downstream environment takes master.
interface ocx_tlx_ctl_router_if;
    logic [167:0] pars_ctl_info;
    logic         pars_ctl_valid;
    logic         pars_ctl_ready;
    logic [55:0]  ctl_vc0_bus;
    logic         ctl_vc0_v;
    logic         ctl_vc0_rd;
    logic [167:0] ctl_vc1_bus;
    logic         ctl_vc1_v;
    logic         ctl_vc1_rd;
    logic [1:0]   data_flit_v;
    logic [1:0]   data_arb_vc_v;
    logic [2:0]   data_arb_flit_cnt;
    logic         data_arb_cfg_hint;
    logic [3:0]   data_arb_cfg_offset;
    logic [55:0]  credit_return;
    logic         credit_return_v;
    logic [3:0]   rcv_xmt_credit_vcx0;
    logic [3:0]   rcv_xmt_credit_vcx3;
    logic [5:0]   rcv_xmt_credit_dcpx0;
    logic [5:0]   rcv_xmt_credit_dcpx3;
    logic         rcv_xmt_credit_tlx_v;
    logic [1:0]   ctl_err;

    modport slave (
        input  pars_ctl_info, pars_ctl_valid, ctl_vc0_rd, ctl_vc1_rd, data_flit_v,
               credit_return, credit_return_v,
        output pars_ctl_ready, ctl_vc0_bus, ctl_vc0_v, ctl_vc1_bus, ctl_vc1_v,
               data_arb_vc_v, data_arb_flit_cnt, data_arb_cfg_hint, data_arb_cfg_offset,
               rcv_xmt_credit_vcx0, rcv_xmt_credit_vcx3, rcv_xmt_credit_dcpx0,
               rcv_xmt_credit_dcpx3, rcv_xmt_credit_tlx_v, ctl_err
    );

    modport master (
        output pars_ctl_info, pars_ctl_valid, ctl_vc0_rd, ctl_vc1_rd, data_flit_v,
               credit_return, credit_return_v,
        input  pars_ctl_ready, ctl_vc0_bus, ctl_vc0_v, ctl_vc1_bus, ctl_vc1_v,
               data_arb_vc_v, data_arb_flit_cnt, data_arb_cfg_hint, data_arb_cfg_offset,
               rcv_xmt_credit_vcx0, rcv_xmt_credit_vcx3, rcv_xmt_credit_dcpx0,
               rcv_xmt_credit_dcpx3, rcv_xmt_credit_tlx_v, ctl_err
    );
endinterface

// File: rtl/ocx_tlx_ctl_router.sv
// TLX control-flit router: opcode classification into VC0/VC1 FIFOs, optional data-hold gating
// of data-bearing heads (enabled by OCX_TLX_CTL_DATA_HOLD_EN) and registered credit returns.
module ocx_tlx_ctl_router #(
    parameter int unsigned VC0_DEPTH = 8,
    parameter int unsigned VC1_DEPTH = 8,
    parameter int unsigned CNT_W     = 6
) (
    input logic                 tlx_clk,
    input logic                 reset_n,
    ocx_tlx_ctl_router_if.slave bus
);
    localparam int unsigned AW0 = $clog2(VC0_DEPTH);
    localparam int unsigned AW1 = $clog2(VC1_DEPTH);
    localparam int unsigned W0  = 60;   // {need[2:0], hasdata, payload[55:0]}
    localparam int unsigned W1  = 172;  // {need[2:0], hasdata, payload[167:0]}

    logic [7:0] opcode;
    logic       drop, to_vc1, hasdata;
    logic [1:0] dl;
    logic [2:0] need;

    assign opcode = bus.pars_ctl_info[7:0];

    always_comb begin
        drop    = (opcode == 8'h00) || (opcode == 8'h08);
        to_vc1  = |opcode[7:5];
        hasdata = 1'b0;
        dl      = 2'b00;
        case (opcode)
            8'h01, 8'h03: begin
                hasdata = 1'b1;
                dl      = bus.pars_ctl_info[27:26];
            end
            8'h81: begin
                hasdata = 1'b1;
                dl      = bus.pars_ctl_info[111:110];
            end
            8'h82, 8'h86, 8'hE1: hasdata = 1'b1;
            default: ;
        endcase
        case (dl)
            2'b10:   need = 3'd2;
            2'b11:   need = 3'd4;
            default: need = 3'd1;
        endcase
    end

    logic          ready, accept, push0, push1, pop0, pop1, rel0, rel1, ovf;
    logic [W0-1:0] mem0 [VC0_DEPTH];
    logic [W1-1:0] mem1 [VC1_DEPTH];
    logic [AW0:0]  wr0_q, rd0_q;
    logic [AW1:0]  wr1_q, rd1_q;
    logic [W0-1:0] head0;
    logic [W1-1:0] head1;
    logic          empty0, empty1, full0, full1;

    assign head0  = mem0[rd0_q[AW0-1:0]];
    assign head1  = mem1[rd1_q[AW1-1:0]];
    assign empty0 = (wr0_q == rd0_q);
    assign empty1 = (wr1_q == rd1_q);
    assign full0  = (wr0_q[AW0] != rd0_q[AW0]) && (wr0_q[AW0-1:0] == rd0_q[AW0-1:0]);
    assign full1  = (wr1_q[AW1] != rd1_q[AW1]) && (wr1_q[AW1-1:0] == rd1_q[AW1-1:0]);

    // Ready looks at both FIFOs so it never depends on the incoming opcode.
    assign ready  = !full0 && !full1;
    assign accept = bus.pars_ctl_valid && ready;
    assign push0  = accept && !drop && !to_vc1;
    assign push1  = accept && !drop && to_vc1;
    assign pop0   = bus.ctl_vc0_rd && rel0;
    assign pop1   = bus.ctl_vc1_rd && rel1;

    always_ff @(posedge tlx_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < VC0_DEPTH; i++) mem0[i] <= '0;
            for (int unsigned i = 0; i < VC1_DEPTH; i++) mem1[i] <= '0;
            wr0_q <= '0;
            rd0_q <= '0;
            wr1_q <= '0;
            rd1_q <= '0;
        end else begin
            if (push0) begin
                mem0[wr0_q[AW0-1:0]] <= {need, hasdata, bus.pars_ctl_info[55:0]};
                wr0_q                <= wr0_q + (AW0 + 1)'(1);
            end
            if (push1) begin
                mem1[wr1_q[AW1-1:0]] <= {need, hasdata, bus.pars_ctl_info};
                wr1_q                <= wr1_q + (AW1 + 1)'(1);
            end
            if (pop0) rd0_q <= rd0_q + (AW0 + 1)'(1);
            if (pop1) rd1_q <= rd1_q + (AW1 + 1)'(1);
        end
    end

`ifdef OCX_TLX_CTL_DATA_HOLD_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic             dec0, dec1, ovf0, ovf1;

    assign dec0 = pop0 && head0[56];
    assign dec1 = pop1 && head1[168];

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        ovf0   = 1'b0;
        ovf1   = 1'b0;
        // Saturation only bites when no pop absorbs the incoming flit.
        if (bus.data_flit_v[0] && !dec0 && (&cnt0_q)) begin
            ovf0 = 1'b1;
        end else begin
            cnt0_d = cnt0_q + CNT_W'(bus.data_flit_v[0]) - (dec0 ? CNT_W'(head0[59:57]) : '0);
        end
        if (bus.data_flit_v[1] && !dec1 && (&cnt1_q)) begin
            ovf1 = 1'b1;
        end else begin
            cnt1_d = cnt1_q + CNT_W'(bus.data_flit_v[1]) - (dec1 ? CNT_W'(head1[171:169]) : '0);
        end
    end

    always_ff @(posedge tlx_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign rel0 = !empty0 && (!head0[56] || (cnt0_q >= CNT_W'(head0[59:57])));
    assign rel1 = !empty1 && (!head1[168] || (cnt1_q >= CNT_W'(head1[171:169])));
    assign ovf  = ovf0 || ovf1;
`else
    logic unused_hold;
    assign unused_hold = ^{bus.data_flit_v, head0[59:56], head1[171:168]};

    assign rel0 = !empty0;
    assign rel1 = !empty1;
    assign ovf  = 1'b0;
`endif

    logic [1:0] err_q;
    logic [3:0] vcx0_q, vcx3_q;
    logic [5:0] dcpx0_q, dcpx3_q;
    logic       tlx_v_q;

    always_ff @(posedge tlx_clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q   <= '0;
            vcx0_q  <= '0;
            vcx3_q  <= '0;
            dcpx0_q <= '0;
            dcpx3_q <= '0;
            tlx_v_q <= 1'b0;
        end else begin
            err_q[0] <= err_q[0] || (bus.pars_ctl_valid && !ready);
            err_q[1] <= err_q[1] || ovf;
            if (bus.credit_return_v) begin
                vcx0_q  <= bus.credit_return[11:8];
                vcx3_q  <= bus.credit_return[15:12];
                dcpx0_q <= bus.credit_return[37:32];
                dcpx3_q <= bus.credit_return[43:38];
            end
            tlx_v_q <= bus.credit_return_v;
        end
    end

    logic unused_credit;
    assign unused_credit = ^{bus.credit_return[55:44], bus.credit_return[31:16],
                             bus.credit_return[7:0]};

    assign bus.pars_ctl_ready       = ready;
    assign bus.ctl_vc0_bus          = head0[55:0];
    assign bus.ctl_vc1_bus          = head1[167:0];
    assign bus.ctl_vc0_v            = rel0;
    assign bus.ctl_vc1_v            = rel1;
    assign bus.data_arb_vc_v        = {push1 && hasdata, push0 && hasdata};
    assign bus.data_arb_flit_cnt    = ((push0 || push1) && hasdata) ? need : 3'd0;
    assign bus.data_arb_cfg_hint    = accept && (opcode == 8'hE1);
    assign bus.data_arb_cfg_offset  = accept ? bus.pars_ctl_info[33:30] : 4'h0;
    assign bus.rcv_xmt_credit_vcx0  = vcx0_q;
    assign bus.rcv_xmt_credit_vcx3  = vcx3_q;
    assign bus.rcv_xmt_credit_dcpx0 = dcpx0_q;
    assign bus.rcv_xmt_credit_dcpx3 = dcpx3_q;
    assign bus.rcv_xmt_credit_tlx_v = tlx_v_q;
    assign bus.ctl_err              = err_q;
endmodule

// File: tb/tb_ocx_tlx_ctl_router.sv
// Randomised bench for ocx_tlx_ctl_router against a queue-based reference model, plus
// directed scenarios; hold-specific cases build only with OCX_TLX_CTL_DATA_HOLD_EN.
module tb_ocx_tlx_ctl_router;
    localparam int D0   = 8;
    localparam int D1   = 8;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;
`ifdef OCX_TLX_CTL_DATA_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic tlx_clk = 1'b0;
    logic reset_n;
    always #5 tlx_clk = ~tlx_clk;

    ocx_tlx_ctl_router_if rif ();

    ocx_tlx_ctl_router #(.VC0_DEPTH(D0), .VC1_DEPTH(D1), .CNT_W(CW)) dut (
        .tlx_clk(tlx_clk),
        .reset_n(reset_n),
        .bus    (rif)
    );

    typedef struct {
        logic [167:0] info;
        bit           hd;
        int           need;
    } ent_t;

    ent_t        q0[$];
    ent_t        q1[$];
    int          cnt0, cnt1;
    bit   [1:0]  m_err;
    logic [55:0] m_cr;
    bit          m_crv;
    int          total, bad;
    logic [7:0]  ops [11] = '{8'h00, 8'h08, 8'h01, 8'h03, 8'h05, 8'h20,
                              8'h81, 8'h82, 8'h86, 8'hE1, 8'h4C};

    task automatic check_eq(input string tag, input logic [167:0] obs, input logic [167:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        q0.delete();
        q1.delete();
        cnt0  = 0;
        cnt1  = 0;
        m_err = '0;
        m_cr  = '0;
        m_crv = 1'b0;
    endfunction

    // Reference classification straight from the opcode rules.
    function automatic void classify(input logic [167:0] info, output bit drop, output bit vc1,
                                     output bit hd, output int need);
        int op;
        int dl;
        op   = int'(info[7:0]);
        drop = (op == 0) || (op == 8);
        vc1  = op >= 32;
        hd   = 1'b0;
        dl   = 0;
        if (op == 1 || op == 3) begin
            hd = 1'b1;
            dl = int'(info[27:26]);
        end else if (op == 'h81) begin
            hd = 1'b1;
            dl = int'(info[111:110]);
        end else if (op == 'h82 || op == 'h86 || op == 'hE1) begin
            hd = 1'b1;
        end
        need = (dl == 0) ? 1 : (1 << (dl - 1));
    endfunction

    function automatic logic [167:0] mk(input logic [7:0] op, input logic [1:0] dl);
        logic [167:0] v;
        v = '0;
        for (int i = 0; i < 6; i++) v = {v[135:0], $urandom()};
        v[7:0]     = op;
        v[27:26]   = dl;
        v[111:110] = dl;
        return v;
    endfunction

    function automatic logic [55:0] rnd56();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[55:0];
    endfunction

    task automatic step(input bit valid, input logic [167:0] info, input bit rd0, input bit rd1,
                        input bit [1:0] flit, input bit crv, input logic [55:0] cr);
        bit   drop, vc1, hd, e_ready, e_v0, e_v1, acc, p0, p1;
        int   need, dec;
        ent_t e;
        @(negedge tlx_clk);
        rif.pars_ctl_valid  = valid;
        rif.pars_ctl_info   = info;
        rif.ctl_vc0_rd      = rd0;
        rif.ctl_vc1_rd      = rd1;
        rif.data_flit_v     = flit;
        rif.credit_return_v = crv;
        rif.credit_return   = cr;
        #1;
        classify(info, drop, vc1, hd, need);
        e_ready = (q0.size() < D0) && (q1.size() < D1);
        e_v0    = (q0.size() > 0) && (!HOLD || !q0[0].hd || cnt0 >= q0[0].need);
        e_v1    = (q1.size() > 0) && (!HOLD || !q1[0].hd || cnt1 >= q1[0].need);
        acc     = valid && e_ready;
        check_eq("ready", rif.pars_ctl_ready, e_ready);
        check_eq("vc0_v", rif.ctl_vc0_v, e_v0);
        check_eq("vc1_v", rif.ctl_vc1_v, e_v1);
        if (e_v0) check_eq("vc0_bus", rif.ctl_vc0_bus, q0[0].info[55:0]);
        if (e_v1) check_eq("vc1_bus", rif.ctl_vc1_bus, q1[0].info);
        check_eq("arb_vc_v", rif.data_arb_vc_v, (acc && hd) ? (vc1 ? 2 : 1) : 0);
        check_eq("arb_flit_cnt", rif.data_arb_flit_cnt, (acc && hd) ? need : 0);
        check_eq("arb_hint", rif.data_arb_cfg_hint, acc && (info[7:0] == 8'hE1));
        check_eq("arb_offset", rif.data_arb_cfg_offset, acc ? info[33:30] : 4'h0);
        check_eq("cr_vcx0", rif.rcv_xmt_credit_vcx0, m_cr[11:8]);
        check_eq("cr_vcx3", rif.rcv_xmt_credit_vcx3, m_cr[15:12]);
        check_eq("cr_dcpx0", rif.rcv_xmt_credit_dcpx0, m_cr[37:32]);
        check_eq("cr_dcpx3", rif.rcv_xmt_credit_dcpx3, m_cr[43:38]);
        check_eq("cr_tlx_v", rif.rcv_xmt_credit_tlx_v, m_crv);
        check_eq("err", rif.ctl_err, m_err);

        p0 = rd0 && e_v0;
        p1 = rd1 && e_v1;
        if (HOLD) begin
            dec = (p0 && q0[0].hd) ? q0[0].need : 0;
            if (flit[0] && dec == 0 && cnt0 == CMAX) m_err[1] = 1'b1;
            else cnt0 = cnt0 + int'(flit[0]) - dec;
            dec = (p1 && q1[0].hd) ? q1[0].need : 0;
            if (flit[1] && dec == 0 && cnt1 == CMAX) m_err[1] = 1'b1;
            else cnt1 = cnt1 + int'(flit[1]) - dec;
        end
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc && !drop) begin
            e.info = info;
            e.hd   = hd;
            e.need = need;
            if (vc1) q1.push_back(e);
            else q0.push_back(e);
        end
        if (valid && !e_ready) m_err[0] = 1'b1;
        if (crv) m_cr = cr;
        m_crv = crv;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b0, '0);
    endtask

    task automatic push(input logic [167:0] info, input bit [1:0] flit);
        step(1'b1, info, 1'b0, 1'b0, flit, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(negedge tlx_clk);
        rif.pars_ctl_valid  = 1'b0;
        rif.ctl_vc0_rd      = 1'b0;
        rif.ctl_vc1_rd      = 1'b0;
        rif.data_flit_v     = 2'b00;
        rif.credit_return_v = 1'b0;
        reset_n             = 1'b0;
        #1;
        model_clear();
        check_eq("rst_ready", rif.pars_ctl_ready, 1'b1);
        check_eq("rst_vc0_v", rif.ctl_vc0_v, 1'b0);
        check_eq("rst_vc1_v", rif.ctl_vc1_v, 1'b0);
        check_eq("rst_err", rif.ctl_err, 2'b00);
        @(negedge tlx_clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [55:0] cr;
        total = 0;
        bad   = 0;
        model_clear();
        reset_n             = 1'b1;
        rif.pars_ctl_valid  = 1'b0;
        rif.pars_ctl_info   = '0;
        rif.ctl_vc0_rd      = 1'b0;
        rif.ctl_vc1_rd      = 1'b0;
        rif.data_flit_v     = 2'b00;
        rif.credit_return_v = 1'b0;
        rif.credit_return   = '0;
        #1 reset_n = 1'b0;
        #1;
        check_eq("rst_ready", rif.pars_ctl_ready, 1'b1);
        check_eq("rst_vc0_v", rif.ctl_vc0_v, 1'b0);
        check_eq("rst_vc1_v", rif.ctl_vc1_v, 1'b0);
        check_eq("rst_vc0_bus", rif.ctl_vc0_bus, 56'h0);
        check_eq("rst_vc1_bus", rif.ctl_vc1_bus, 168'h0);
        check_eq("rst_err", rif.ctl_err, 2'b00);
        check_eq("rst_vcx0", rif.rcv_xmt_credit_vcx0, 4'h0);
        check_eq("rst_dcpx3", rif.rcv_xmt_credit_dcpx3, 6'h0);
        check_eq("rst_tlx_v", rif.rcv_xmt_credit_tlx_v, 1'b0);
        #20;
        @(negedge tlx_clk);
        reset_n = 1'b1;

        // Drops and VC1 steering.
        push(mk(8'h00, 2'b00), 2'b00);
        push(mk(8'h08, 2'b00), 2'b00);
        push(mk(8'h20, 2'b00), 2'b00);
        push(mk(8'h81, 2'b00), 2'b00);
        idle();
        check_eq("drop_vc0_v", rif.ctl_vc0_v, 1'b0);
        check_eq("drop_vc1_head", rif.ctl_vc1_bus[7:0], 8'h20);
        step(1'b0, '0, 1'b0, 1'b1, 2'b10, 1'b0, '0);
        idle();
        check_eq("drop_vc1_next", rif.ctl_vc1_bus[7:0], 8'h81);
        check_eq("drop_vc1_next_v", rif.ctl_vc1_v, 1'b1);
        do_reset();

        // Fill VC0; one flit up front so the head can pop under data hold.
        push(mk(8'h03, 2'b00), 2'b01);
        for (int i = 1; i < D0; i++) push(mk(8'h03, 2'b00), 2'b00);
        idle();
        check_eq("full_ready", rif.pars_ctl_ready, 1'b0);
        push(mk(8'h03, 2'b00), 2'b00);
        idle();
        check_eq("full_err0", rif.ctl_err[0], 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 2'b00, 1'b0, '0);
        idle();
        check_eq("pop_ready", rif.pars_ctl_ready, 1'b1);
        do_reset();

`ifdef OCX_TLX_CTL_DATA_HOLD_EN
        push(mk(8'h81, 2'b11), 2'b00);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 2'b10, 1'b0, '0);
        idle();
        check_eq("hold_v1_3flits", rif.ctl_vc1_v, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 2'b10, 1'b0, '0);
        idle();
        check_eq("hold_v1_4flits", rif.ctl_vc1_v, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 2'b00, 1'b0, '0);
        push(mk(8'h81, 2'b00), 2'b00);
        idle();
        check_eq("hold_cnt_zero", rif.ctl_vc1_v, 1'b0);
        do_reset();

        push(mk(8'h01, 2'b01), 2'b01);
        idle();
        check_eq("hold_v0_cnt1", rif.ctl_vc0_v, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 2'b01, 1'b0, '0);
        push(mk(8'h01, 2'b10), 2'b00);
        idle();
        check_eq("hold_net_lo", rif.ctl_vc0_v, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 2'b01, 1'b0, '0);
        idle();
        check_eq("hold_net_hi", rif.ctl_vc0_v, 1'b1);
        do_reset();
`endif

        // Credit capture and hold.
        cr        = rnd56();
        cr[11:8]  = 4'h5;
        cr[37:32] = 6'h2A;
        step(1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b1, cr);
        idle();
        check_eq("cr_vcx0_cap", rif.rcv_xmt_credit_vcx0, 4'h5);
        check_eq("cr_dcpx0_cap", rif.rcv_xmt_credit_dcpx0, 6'h2A);
        check_eq("cr_tlx_v_hi", rif.rcv_xmt_credit_tlx_v, 1'b1);
        idle();
        check_eq("cr_tlx_v_lo", rif.rcv_xmt_credit_tlx_v, 1'b0);
        check_eq("cr_vcx0_hold", rif.rcv_xmt_credit_vcx0, 4'h5);

        // Asynchronous reset with entries queued.
        push(mk(8'h20, 2'b00), 2'b00);
        push(mk(8'h40, 2'b00), 2'b00);
        push(mk(8'h05, 2'b00), 2'b00);
        idle();
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_vc0_v", rif.ctl_vc0_v, 1'b0);
        check_eq("arst_vc1_v", rif.ctl_vc1_v, 1'b0);
        check_eq("arst_ready", rif.pars_ctl_ready, 1'b1);
        model_clear();
        @(negedge tlx_clk);
        reset_n = 1'b1;
        idle();
        check_eq("arst_empty0", rif.ctl_vc0_v, 1'b0);
        check_eq("arst_empty1", rif.ctl_vc1_v, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            logic [7:0] op;
            logic [1:0] dl;
            int         k;
            k  = $urandom_range(0, 11);
            op = (k == 11) ? 8'($urandom()) : ops[k];
            dl = 2'($urandom());
            if (n == 1500) do_reset();
            step($urandom_range(0, 99) < 60, mk(op, dl), $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 40, 2'($urandom()), $urandom_range(0, 9) == 0,
                 rnd56());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
